// File: rtl/host_link_ctrl.sv
// Host-side sequencer: streams host words into shared memory, starts the cores,
// waits for completion (optional watchdog), then dumps a memory window to the host.
module host_link_ctrl #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 16,
    parameter int MEM_WORDS      = 4096,
    parameter int DUMP_BASE      = 0,
    parameter int DUMP_WORDS     = 1024,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              load_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        status,
    output logic              proc_start,
    input  logic              proc_done,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_start,
    output logic              out_done,
    output logic [ADDR_W:0]   load_count,
    output logic              err_overflow,
    output logic              err_timeout
);

    localparam int CW = ADDR_W + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1) + 1;
    localparam logic [CW-1:0]     MEM_LIM = CW'(MEM_WORDS);
    localparam logic [CW-1:0]     DUMP_N  = CW'(DUMP_WORDS);
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(DUMP_BASE);
    localparam logic [TW-1:0]     TMO     = TW'(TIMEOUT_CYCLES);

    // State encoding doubles as the phase code the cores observe.
    typedef enum logic [1:0] {
        S_LOAD = 2'b00,
        S_RUN  = 2'b01,
        S_DUMP = 2'b10,
        S_IDLE = 2'b11
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]     wptr;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [ADDR_W-1:0] rptr;
    logic [ADDR_W-1:0] last_rd;
    logic [CW-1:0]     rd_left;
    logic [CW-1:0]     xfer_left;
    logic [TW-1:0]     wdog;

    logic in_dump, wr_ok, issue, stall, xfer, last_xfer, tmo_hit;

    assign in_dump   = (state == S_DUMP);
    assign wr_ok     = in_valid && (wptr < MEM_LIM);
    assign issue     = in_dump && (rd_left != '0) && (!out_valid || out_ready);
    assign stall     = in_dump && out_valid && !out_ready;
    assign xfer      = in_dump && out_valid && out_ready;
    assign last_xfer = xfer && (xfer_left == CW'(1));
    assign tmo_hit   = (TIMEOUT_CYCLES != 0) && (wdog == TMO);

    assign status     = state;
    assign load_count = wptr;
    assign out_data   = mem_rdata;
    // Re-reading the in-flight address on a stall keeps mem_rdata/out_data steady.
    assign mem_rd_en  = issue || stall;
    assign mem_addr   = in_dump ? (issue ? rptr : last_rd) : wr_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (load_start)           state_nxt = S_LOAD;
            S_LOAD: if (load_done)            state_nxt = S_RUN;
            S_RUN:  if (proc_done || tmo_hit) state_nxt = S_DUMP;
            S_DUMP: if (last_xfer)            state_nxt = S_IDLE;
            default:                          state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr         <= '0;
            wr_addr_q    <= '0;
            mem_wdata    <= '0;
            mem_wr_en    <= 1'b0;
            rptr         <= '0;
            last_rd      <= '0;
            rd_left      <= '0;
            xfer_left    <= '0;
            wdog         <= '0;
            proc_start   <= 1'b0;
            out_valid    <= 1'b0;
            out_start    <= 1'b0;
            out_done     <= 1'b0;
            err_overflow <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            mem_wr_en  <= 1'b0;
            proc_start <= 1'b0;
            out_start  <= 1'b0;
            out_done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (load_start) begin
                        wptr         <= '0;
                        err_overflow <= 1'b0;
                        err_timeout  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (wr_ok) begin
                        mem_wr_en <= 1'b1;
                        wr_addr_q <= wptr[ADDR_W-1:0];
                        mem_wdata <= in_data;
                        wptr      <= wptr + CW'(1);
                    end else if (in_valid) begin
                        err_overflow <= 1'b1;
                    end
                    if (load_done) begin
                        proc_start <= 1'b1;
                        wdog       <= '0;
                    end
                end
                S_RUN: begin
                    wdog <= wdog + TW'(1);
                    if (proc_done || tmo_hit) begin
                        // A completion on the limit cycle takes priority over the watchdog.
                        if (!proc_done) err_timeout <= 1'b1;
                        out_start <= 1'b1;
                        rptr      <= BASE;
                        last_rd   <= BASE;
                        rd_left   <= DUMP_N;
                        xfer_left <= DUMP_N;
                        out_valid <= 1'b0;
                    end
                end
                S_DUMP: begin
                    if (issue) begin
                        last_rd   <= rptr;
                        if (rd_left != CW'(1)) rptr <= rptr + ADDR_W'(1);
                        rd_left   <= rd_left - CW'(1);
                        out_valid <= 1'b1;
                    end else if (xfer) begin
                        out_valid <= 1'b0;
                    end
                    if (xfer) xfer_left <= xfer_left - CW'(1);
                    if (last_xfer) out_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_host_link_ctrl.sv
// Directed bench for host_link_ctrl: vector tables for load phases plus
// hand-written sequences for run/watchdog, dump backpressure and reset abort.
module tb_host_link_ctrl;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int MW = 8;
    localparam int DN = 8;
    localparam int TO = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_start, in_valid, load_done, proc_done, out_ready;
    logic [DW-1:0] in_data;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata, out_data;
    logic          mem_wr_en, mem_rd_en, proc_start, out_valid, out_start, out_done;
    logic [1:0]    status;
    logic [AW:0]   load_count;
    logic          err_overflow, err_timeout;

    always #5 clk = ~clk;

    host_link_ctrl #(
        .DATA_W(DW), .ADDR_W(AW), .MEM_WORDS(MW), .DUMP_BASE(0),
        .DUMP_WORDS(DN), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .in_data(in_data),
        .in_valid(in_valid), .load_done(load_done), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
        .mem_rdata(mem_rdata), .status(status), .proc_start(proc_start),
        .proc_done(proc_done), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_start(out_start), .out_done(out_done),
        .load_count(load_count), .err_overflow(err_overflow), .err_timeout(err_timeout)
    );

    // Shared data memory with one-cycle read latency.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          ls, iv;
        logic [DW-1:0] d;
        logic          ld;
        logic          e_wr;
        logic [AW-1:0] e_addr;
        logic [AW:0]   e_cnt;
        logic          e_ovf;
        logic [1:0]    e_st;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic ls, input logic iv, input logic [DW-1:0] d,
                                input logic ld, input logic e_wr, input logic [AW-1:0] e_addr,
                                input logic [AW:0] e_cnt, input logic e_ovf, input logic [1:0] e_st);
        vec_t v;
        v.ls = ls; v.iv = iv; v.d = d; v.ld = ld; v.e_wr = e_wr;
        v.e_addr = e_addr; v.e_cnt = e_cnt; v.e_ovf = e_ovf; v.e_st = e_st;
        return v;
    endfunction

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            vec_t v;
            v = vecs[i];
            load_start = v.ls; in_valid = v.iv; in_data = v.d; load_done = v.ld;
            tick();
            chk($sformatf("vec%0d wr_en", i), mem_wr_en, v.e_wr);
            if (v.e_wr) begin
                chk($sformatf("vec%0d addr", i), mem_addr, v.e_addr);
                chk($sformatf("vec%0d wdata", i), mem_wdata, v.d);
            end
            chk($sformatf("vec%0d load_count", i), load_count, v.e_cnt);
            chk($sformatf("vec%0d err_overflow", i), err_overflow, v.e_ovf);
            chk($sformatf("vec%0d status", i), status, v.e_st);
        end
        load_start = 1'b0; in_valid = 1'b0; load_done = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " status"}, status, 2'b11);
        chk({tag, " mem_addr"}, mem_addr, 0);
        chk({tag, " mem_wdata"}, mem_wdata, 0);
        chk({tag, " load_count"}, load_count, 0);
        chk({tag, " mem_wr_en"}, mem_wr_en, 0);
        chk({tag, " mem_rd_en"}, mem_rd_en, 0);
        chk({tag, " proc_start"}, proc_start, 0);
        chk({tag, " out_valid"}, out_valid, 0);
        chk({tag, " out_start"}, out_start, 0);
        chk({tag, " out_done"}, out_done, 0);
        chk({tag, " err_overflow"}, err_overflow, 0);
        chk({tag, " err_timeout"}, err_timeout, 0);
    endtask

    logic [DW-1:0] exp_words [DN];
    bit            rdy_pat[$];

    // Entered in the first DUMP cycle; returns in the out_done cycle.
    task automatic dump(input string tag, input int exp_cycles);
        int            idx = 0;
        int            cyc = 0;
        logic          stalled = 1'b0;
        logic [DW-1:0] held = '0;
        chk({tag, " out_start"}, out_start, 1);
        chk({tag, " status dump"}, status, 2'b10);
        while (idx < DN && cyc < 100) begin
            out_ready = rdy_pat[cyc % rdy_pat.size()];
            #1;
            if (stalled) chk($sformatf("%s stall data w%0d", tag, idx), out_data, held);
            stalled = 1'b0;
            if (out_valid && out_ready) begin
                chk($sformatf("%s word%0d", tag, idx), out_data, exp_words[idx]);
                idx++;
            end else if (out_valid) begin
                chk($sformatf("%s stall addr w%0d", tag, idx), mem_addr, idx);
                chk($sformatf("%s stall rd_en w%0d", tag, idx), mem_rd_en, 1);
                stalled = 1'b1;
                held    = out_data;
            end
            cyc++;
            @(posedge clk);
            #1;
        end
        chk({tag, " handshakes"}, idx, DN);
        chk({tag, " out_done"}, out_done, 1);
        chk({tag, " status idle"}, status, 2'b11);
        chk({tag, " out_valid after"}, out_valid, 0);
        if (exp_cycles != 0) chk({tag, " dump cycles"}, cyc, exp_cycles);
        out_ready = 1'b0;
    endtask

    initial begin
        int ps, n;
        // Gapped load: six words on alternate cycles, load_done with the last.
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 0, 0, 2'b00));
        vecs.push_back(mk(0, 1, 16'hB000, 0, 1, 0, 1, 0, 2'b00));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 1, 0, 2'b00));
        vecs.push_back(mk(0, 1, 16'hB001, 0, 1, 1, 2, 0, 2'b00));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 2, 0, 2'b00));
        vecs.push_back(mk(0, 1, 16'hB002, 0, 1, 2, 3, 0, 2'b00));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 3, 0, 2'b00));
        vecs.push_back(mk(0, 1, 16'hB003, 0, 1, 3, 4, 0, 2'b00));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 4, 0, 2'b00));
        vecs.push_back(mk(0, 1, 16'hB004, 0, 1, 4, 5, 0, 2'b00));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 5, 0, 2'b00));
        vecs.push_back(mk(0, 1, 16'hB005, 1, 1, 5, 6, 0, 2'b01));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 6, 0, 2'b01));
        // Overflow: ten words into an eight-word memory.
        vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 0, 0, 2'b00));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, 1, 16'(16'hC000 + i), 0, 1, 8'(i), 9'(i + 1), 0, 2'b00));
        vecs.push_back(mk(0, 1, 16'hC008, 0, 0, 0, 8, 1, 2'b00));
        vecs.push_back(mk(0, 1, 16'hC009, 1, 0, 0, 8, 1, 2'b01));

        rst_n = 1'b0; load_start = 0; in_valid = 0; in_data = '0; load_done = 0;
        proc_done = 0; out_ready = 0;
        #12;
        check_reset("reset");
        rst_n = 1'b1;
        tick();

        // Basic flow
        load_start = 1; tick(); load_start = 0;
        chk("basic status load", status, 2'b00);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1; in_data = 16'(16'hA000 + i); load_done = (i == 7);
            tick();
            chk($sformatf("basic wr_en%0d", i), mem_wr_en, 1);
            chk($sformatf("basic addr%0d", i), mem_addr, i);
            chk($sformatf("basic wdata%0d", i), mem_wdata, 16'hA000 + i);
        end
        in_valid = 0; load_done = 0;
        chk("basic status run", status, 2'b01);
        chk("basic load_count", load_count, 8);
        ps = int'(proc_start);
        for (int k = 0; k < 5; k++) begin tick(); ps += int'(proc_start); end
        chk("basic still run", status, 2'b01);
        proc_done = 1; tick(); proc_done = 0;
        chk("basic proc_start pulses", ps, 1);
        for (int i = 0; i < DN; i++) exp_words[i] = 16'(16'hA000 + i);
        rdy_pat = '{1};
        dump("basic", DN + 1);

        // Gapped load then backpressured dump
        run_vecs(0, 13);
        proc_done = 1; tick(); proc_done = 0;
        for (int i = 0; i < 6; i++) exp_words[i] = 16'(16'hB000 + i);
        exp_words[6] = 16'hA006; exp_words[7] = 16'hA007;
        rdy_pat = '{1, 0, 0, 1, 0, 1};
        dump("bp", 0);

        // Overflow, then watchdog expiry
        run_vecs(13, 24);
        chk("wdog proc_start", proc_start, 1);
        n = 0;
        while (status != 2'b10 && n < 30) begin tick(); n++; end
        chk("wdog run cycles", n, TO + 1);
        chk("wdog err_timeout", err_timeout, 1);
        chk("wdog err_overflow sticky", err_overflow, 1);
        for (int i = 0; i < DN; i++) exp_words[i] = 16'(16'hC000 + i);
        rdy_pat = '{1};
        dump("wdog", DN + 1);

        // proc_done on the watchdog limit cycle wins
        load_start = 1; tick(); load_start = 0;
        chk("limit err_overflow clr", err_overflow, 0);
        chk("limit err_timeout clr", err_timeout, 0);
        chk("limit load_count clr", load_count, 0);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1; in_data = 16'(16'hD000 + i); load_done = (i == 7); tick();
        end
        in_valid = 0; load_done = 0;
        repeat (TO) tick();
        chk("limit still run", status, 2'b01);
        proc_done = 1; tick(); proc_done = 0;
        chk("limit status dump", status, 2'b10);
        chk("limit err_timeout", err_timeout, 0);

        // Abort mid-DUMP with a stalled word outstanding
        out_ready = 0; tick(); tick();
        chk("abort dump out_valid", out_valid, 1);
        #2 rst_n = 0;
        #1 check_reset("abort_dump");
        #2 rst_n = 1;
        tick();

        // Abort mid-LOAD
        load_start = 1; tick(); load_start = 0;
        for (int i = 0; i < 3; i++) begin in_valid = 1; in_data = 16'(16'hE000 + i); tick(); end
        in_valid = 0;
        chk("abort load count", load_count, 3);
        #2 rst_n = 0;
        #1 check_reset("abort_load");
        #2 rst_n = 1;
        tick();

        // Clean restart from address 0
        load_start = 1; tick(); load_start = 0;
        in_valid = 1; in_data = 16'hF000; tick();
        chk("restart wr_en", mem_wr_en, 1);
        chk("restart addr0", mem_addr, 0);
        chk("restart wdata0", mem_wdata, 16'hF000);
        chk("restart count1", load_count, 1);
        in_data = 16'hF001; tick();
        chk("restart addr1", mem_addr, 1);
        chk("restart count2", load_count, 2);
        in_valid = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/host_link_ctrl.md
# host_link_ctrl

Parametrised host-side sequencer for the multi-core array, successor to the fixed 16-bit load/run/dump controller. It streams host words into shared data memory with a per-word valid strobe and overflow guard. It starts the cores, waits for their completion under an optional watchdog, then dumps a configurable memory window back to the host over a valid/ready channel. It sits between the host link interface and the `top` core/memory complex and drives the 2-bit phase `status` that the cores observe.

## Interface
- `DATA_W`, 16, memory/host word width
- `ADDR_W`, 16, memory address width
- `MEM_WORDS`, 4096, loadable words (addresses 0..MEM_WORDS-1); must be ≤ 2^ADDR_W
- `DUMP_BASE`, 0, first dumped address
- `DUMP_WORDS`, 1024, words dumped; ≥1, and DUMP_BASE+DUMP_WORDS ≤ 2^ADDR_W
- `TIMEOUT_CYCLES`, 0, RUN-phase watchdog limit; 0 disables it
- `clk`  in  1  clock, all logic on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `load_start`  in  1  host begins a load; honoured only in IDLE
- `in_data`  in  DATA_W  host word
- `in_valid`  in  1  `in_data` valid this cycle
- `load_done`  in  1  host load finished
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  write data
- `mem_wr_en`  out  1  write strobe
- `mem_rd_en`  out  1  read strobe
- `mem_rdata`  in  DATA_W  read data, valid the cycle after the `mem_rd_en` cycle
- `status`  out  2  phase: 2'b11 IDLE, 2'b00 LOAD, 2'b01 RUN, 2'b10 DUMP
- `proc_start`  out  1  one-cycle pulse to the cores
- `proc_done`  in  1  cores finished (the level or a pulse is accepted)
- `out_data`  out  DATA_W  dump word; combinational copy of `mem_rdata`
- `out_valid`  out  1  `out_data` valid
- `out_ready`  in  1  host accepts; a transfer occurs when `out_valid` && `out_ready`
- `out_start`, `out_done`  out  1  one-cycle pulses at dump entry and dump end
- `load_count`  out  ADDR_W+1  words accepted in the last load, saturating at MEM_WORDS
- `err_overflow`, `err_timeout`  out  1  sticky error flags

## Operation
- Reset: `status`=2'b11. `mem_addr`, `load_count`, the internal counters, `mem_wr_en`, `mem_rd_en`, `proc_start`, `out_valid`, `out_start`, `out_done` and both error flags are 0. `mem_wdata` is 0.
- IDLE: `load_start`=1 moves to LOAD. On that edge the write pointer, `load_count`, `err_overflow` and `err_timeout` clear.
- LOAD, each cycle with `in_valid`:
  - If pointer < MEM_WORDS: the block registers `mem_wr_en`=1, `mem_addr`=pointer and `mem_wdata`=`in_data`, and increments the pointer and `load_count`.
  - Otherwise: no write, `err_overflow` is set, and the pointer holds.
  - A cycle with no `in_valid` registers `mem_wr_en`=0.
- LOAD exit: `load_done` moves to RUN. An `in_valid` word in the same cycle is still written. `proc_start` pulses in the first RUN cycle.
- RUN: the watchdog counter clears on entry and increments every RUN cycle.
  - `proc_done` moves to DUMP.
  - If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES without `proc_done`, `err_timeout` is set and the block moves to DUMP.
  - `proc_done` in the same cycle as the limit wins: no error.
- DUMP: the read pointer starts at DUMP_BASE. `out_start` pulses in the first DUMP cycle.
  - A read issues in cycle t (`mem_rd_en`=1, `mem_addr`=read pointer) when words remain and (!`out_valid` || `out_ready`).
  - `out_valid` is 1 in t+1.
  - On stall (`out_valid` && !`out_ready`), `mem_addr` holds and `mem_rd_en` stays 1, so `mem_rdata` and `out_data` are stable.
  - Exactly DUMP_WORDS words are transferred. After the final handshake, `out_done` pulses in the next cycle and the state returns to IDLE in that same cycle.
- `load_start`, `load_done` and `proc_done` are ignored outside their own states.
- Reset mid-operation returns all outputs to their reset values immediately. Any partial load or dump is abandoned.

## Timing
- Load throughput is 1 word/cycle. The write is visible on the memory port one cycle after `in_valid`.
- The LOAD→RUN edge is the `load_done` cycle +1. `proc_start` is high in that cycle.
- The RUN→DUMP edge is the `proc_done` cycle +1. The first read issues in the first DUMP cycle, and the first `out_valid` follows 1 cycle later.
- Dump throughput is 1 word/cycle with `out_ready` held high. With `out_ready` held high, DUMP lasts DUMP_WORDS+1 cycles, and the `out_done` pulse follows in the next cycle.
- Address arithmetic is unsigned ADDR_W. The dump pointer never exceeds DUMP_BASE+DUMP_WORDS-1, so it does not wrap.

## Test plan
- Basic flow (defaults, scaled to DUMP_WORDS=8): load 8 words 0xA000..0xA007 with continuous `in_valid`, assert `proc_done` 5 cycles after `proc_start`, hold `out_ready`=1.
  - Required: `load_count`=8, `status` sequence 11→00→01→10→11, one `proc_start` pulse, 8 dumped words matching, `out_done` one cycle after the 8th transfer.
- Gapped load: `in_valid` toggled every other cycle over 6 words, with `load_done` asserted together with the last `in_valid`.
  - Required: exactly 6 writes to addresses 0..5; the last word is written.
- Overflow (MEM_WORDS=4): send 6 words.
  - Required: writes to 0..3 only, `err_overflow`=1, `load_count`=4; the flag clears on the next `load_start`.
- Backpressure: `out_ready` pattern 1,0,0,1,0,1…
  - Required: no word is lost or duplicated, `out_data` and `mem_addr` are stable during each stall, and exactly DUMP_WORDS handshakes occur.
- Watchdog (TIMEOUT_CYCLES=10): `proc_done` is never asserted.
  - Required: DUMP is entered 11 cycles after RUN entry with `err_timeout`=1.
  - Repeat with `proc_done` on the limit cycle: `err_timeout`=0.
- Reset abort: drop `rst_n` mid-DUMP and mid-LOAD.
  - Required: all outputs return to their reset values asynchronously, and the next load starts cleanly from address 0.
